// File: rtl/rr_grant_scheduler_pkg.sv
// Shared definitions for the round-robin grant scheduler.
// State encoding, requester geometry and the rotating-priority pick helper.
package rr_grant_scheduler_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Scan ptr+1, ptr+2, ptr+3, ptr; the last owner is served last.
    function automatic pick_t rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr
    );
        pick_t            p;
        logic [IDX_W-1:0] k;
        p.found = 1'b0;
        p.idx   = ptr;
        for (int i = NUM_REQ; i >= 1; i--) begin
            k = ptr + IDX_W'(i);
            if (req[k]) begin
                p.found = 1'b1;
                p.idx   = k;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_grant_scheduler_decoder.sv
// 2-to-4 decoder with enable; drives the resource select lines.
// Output is all-zero when disabled, otherwise exactly one-hot.
module decoder
    import rr_grant_scheduler_pkg::*;
(
    input  logic [IDX_W-1:0]   in,
    input  logic               en,
    output logic [NUM_REQ-1:0] d
);

    always_comb begin
        d = '0;
        if (en) d[in] = 1'b1;
    end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin owner selection for one shared resource among 4 requesters,
// with bounded tenure (timeout preemption) and an optional idle gap between owners.
module rr_grant_scheduler
    import rr_grant_scheduler_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int GAP_EN   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   sel,
    output logic               sel_en,
    output logic               preempt,
    output logic               busy
);

    localparam int                HOLD_W   = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic               sel_en_q, sel_en_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               preempt_q, preempt_d;

    pick_t              pick;
    pick_t              repick;
    logic [NUM_REQ-1:0] own_oh;
    logic               release_c;
    logic               timeout_c;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        sel_en_d   = sel_en_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        preempt_d  = 1'b0;

        pick      = rr_pick(req, ptr_q);
        repick    = rr_pick(req, sel_q);
        own_oh    = NUM_REQ'(1) << sel_q;
        release_c = !req[sel_q];
        timeout_c = (hold_cnt_q == HOLD_MAX) && |(req & ~own_oh);

        unique case (state_q)
            ST_IDLE: begin
                if (pick.found) begin
                    state_d    = ST_GRANT;
                    sel_d      = pick.idx;
                    sel_en_d   = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + 1'b1;
                if (release_c || timeout_c) begin
                    ptr_d     = sel_q;
                    preempt_d = !release_c;
                    if (GAP_EN != 0) begin
                        state_d  = ST_GAP;
                        sel_en_d = 1'b0;
                    end else if (repick.found) begin
                        sel_d      = repick.idx;
                        hold_cnt_d = '0;
                    end else begin
                        state_d  = ST_IDLE;
                        sel_en_d = 1'b0;
                    end
                end
            end
            ST_GAP: begin
                if (pick.found) begin
                    state_d    = ST_GRANT;
                    sel_d      = pick.idx;
                    sel_en_d   = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                sel_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            sel_en_q   <= 1'b0;
            ptr_q      <= IDX_W'(NUM_REQ - 1);
            hold_cnt_q <= '0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            sel_en_q   <= sel_en_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            preempt_q  <= preempt_d;
        end
    end

    decoder u_dec (
        .in (sel_q),
        .en (sel_en_q),
        .d  (gnt)
    );

    assign sel     = sel_q;
    assign sel_en  = sel_en_q;
    assign preempt = preempt_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench: gap-enabled and back-to-back scheduler instances.
// Expected grants are hand-derived from the rotating priority rules.
module tb_rr_grant_scheduler;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] req0;

    logic [3:0] gnt, gnt0;
    logic [1:0] sel, sel0;
    logic       sel_en, sel_en0;
    logic       preempt, preempt0;
    logic       busy, busy0;

    int n_cmp;
    int n_bad;

    rr_grant_scheduler #(.MAX_HOLD(8), .GAP_EN(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .sel     (sel),
        .sel_en  (sel_en),
        .preempt (preempt),
        .busy    (busy)
    );

    rr_grant_scheduler #(.MAX_HOLD(8), .GAP_EN(0)) dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req0),
        .gnt     (gnt0),
        .sel     (sel0),
        .sel_en  (sel_en0),
        .preempt (preempt0),
        .busy    (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_g;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        req   = 4'b1111;
        req0  = 4'b0000;

        // 1 reset with all requests high
        tick(2);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_sel_en", 32'(sel_en), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_preempt", 32'(preempt), 0);
        chk("rst_gnt0", 32'(gnt0), 0);
        rst_n = 1'b1;
        req   = 4'b0000;
        tick();
        chk("idle_busy", 32'(busy), 0);

        // 2 single request, then drop
        req = 4'b0100;
        tick();
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_sel", 32'(sel), 2);
        chk("single_busy", 32'(busy), 1);
        req = 4'b0000;
        tick();
        chk("single_gap_gnt", 32'(gnt), 0);
        chk("single_gap_busy", 32'(busy), 1);
        chk("single_gap_pre", 32'(preempt), 0);
        tick();
        chk("single_idle_busy", 32'(busy), 0);

        // 3 full contention from fresh reset
        do_reset();
        req = 4'b1111;
        tick();
        for (int o = 0; o < 5; o++) begin
            exp_g = 4'b0001 << (o % 4);
            for (int c = 0; c < 8; c++) begin
                chk($sformatf("full_gnt_o%0d_c%0d", o, c), 32'(gnt), 32'(exp_g));
                chk($sformatf("full_pre_o%0d_c%0d", o, c), 32'(preempt), 0);
                tick();
            end
            chk($sformatf("full_gap_gnt_o%0d", o), 32'(gnt), 0);
            chk($sformatf("full_gap_pre_o%0d", o), 32'(preempt), 1);
            tick();
        end
        chk("full_wrap_gnt", 32'(gnt), 32'h2);
        req = 4'b0000;
        tick(2);
        chk("full_end_busy", 32'(busy), 0);

        // 4 lone holder saturates, then a newcomer preempts
        req = 4'b0010;
        tick();
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("lone_gnt_c%0d", c), 32'(gnt), 32'h2);
            chk($sformatf("lone_pre_c%0d", c), 32'(preempt), 0);
            tick();
        end
        req = 4'b1010;
        chk("lone_still", 32'(gnt), 32'h2);
        tick();
        chk("lone_gap_gnt", 32'(gnt), 0);
        chk("lone_gap_pre", 32'(preempt), 1);
        tick();
        chk("lone_new_gnt", 32'(gnt), 32'h8);
        chk("lone_new_pre", 32'(preempt), 0);
        req = 4'b0000;
        tick(2);
        chk("lone_end_busy", 32'(busy), 0);

        // 5a release on the timeout cycle, gap enabled
        req = 4'b0011;
        tick();
        chk("rel_first_gnt", 32'(gnt), 32'h1);
        tick(7);
        chk("rel_last_gnt", 32'(gnt), 32'h1);
        req = 4'b0010;
        tick();
        chk("rel_gap_gnt", 32'(gnt), 0);
        chk("rel_gap_pre", 32'(preempt), 0);
        tick();
        chk("rel_next_gnt", 32'(gnt), 32'h2);
        req = 4'b0000;
        tick(2);

        // 5b same on the back-to-back instance
        req0 = 4'b0011;
        tick();
        chk("b2b_first_gnt", 32'(gnt0), 32'h1);
        tick(7);
        chk("b2b_last_gnt", 32'(gnt0), 32'h1);
        req0 = 4'b0010;
        tick();
        chk("b2b_next_gnt", 32'(gnt0), 32'h2);
        chk("b2b_next_pre", 32'(preempt0), 0);
        req0 = 4'b0011;
        tick(7);
        chk("b2b_hold_gnt", 32'(gnt0), 32'h2);
        tick();
        chk("b2b_tmo_gnt", 32'(gnt0), 32'h1);
        chk("b2b_tmo_pre", 32'(preempt0), 1);
        req0 = 4'b0000;
        tick();
        chk("b2b_idle_gnt", 32'(gnt0), 0);
        chk("b2b_idle_busy", 32'(busy0), 0);

        // 6 reset during requester 2's grant
        do_reset();
        req = 4'b0100;
        tick(3);
        chk("mid_gnt", 32'(gnt), 32'h4);
        rst_n = 1'b0;
        req   = 4'b1111;
        tick();
        chk("mid_rst_gnt", 32'(gnt), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_sel_en", 32'(sel_en), 0);
        rst_n = 1'b1;
        tick();
        chk("mid_after_gnt", 32'(gnt), 32'h1);
        chk("mid_after_sel", 32'(sel), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
